// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline package: stage occupancy encoding and default payload width
// for the skid-buffered stage registers feeding the operand/write-back selectors.
package pipe_skid_reg_pkg;

  localparam int PS_DEFAULT_SIZE = 32;

  // The encoding doubles as the occupancy count presented on count_o
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } ps_state_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline stage register with valid/ready handshake
// and flush; main register drives the selector, skid absorbs one stall word.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int size = PS_DEFAULT_SIZE
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [size-1:0] in_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [size-1:0] out_data_o,
  output logic [1:0]      count_o
);

  ps_state_e       state_q;
  ps_state_e       state_d;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [size-1:0] main_q;
  logic [size-1:0] skid_q;

  logic in_fire;
  logic out_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = out_valid_q & out_ready_i;

  // Next occupancy and payload moves; a flush squashes every load but an
  // accompanying out_fire has still been taken by downstream.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = PS_EMPTY;
    end else begin
      unique case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_d      = PS_ONE;
          end
        end
        PS_ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_d   = PS_FULL;
          end else if (out_fire) begin
            state_d = PS_EMPTY;
          end
        end
        PS_FULL: begin
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_d        = PS_ONE;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  // Handshake flags are registered off the next state so in_ready_o never
  // sees a combinational path from out_ready_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= PS_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != PS_FULL);
      out_valid_q <= (state_d != PS_EMPTY);
    end
  end

  // Payload is never cleared on pop, only by reset; consumers qualify with valid
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_data_i;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data_i;
      end
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;
  assign count_o     = state_q;

endmodule
